// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Takes a framed word stream (length header, payload, checksum) and writes the
// payload into instruction memory from address 0 upward. The CPU core is held
// in reset until the image has been written and its checksum verifies.
module imem_loader #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int RST_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LOAD,
      S_CSUM,
      S_HOLD,
      S_RUN,
      S_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_LEN   = 2'd1;
   localparam logic [1:0] ERR_FRAME = 2'd2;
   localparam logic [1:0] ERR_CSUM  = 2'd3;

   // A full-memory image (N = depth) is legal, so lengths need ADDR_W+1 bits.
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [1:0]          err_q, err_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                ready_q, ready_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                accept;
   logic [ADDR_W:0]     hdr_len;
   logic [ADDR_W:0]     cnt_inc;

   assign accept  = s_valid && ready_q;
   assign hdr_len = s_data[ADDR_W:0];
   assign cnt_inc = cnt_q + (ADDR_W+1)'(1);

   // Next-state, datapath updates and registered output decode.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      hold_d    = hold_q;
      err_d     = err_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;

      case (state_q)
         S_IDLE, S_RUN, S_ERROR: begin
            // start begins a fresh load from any resting state, including a reload.
            if (start) begin
               state_d = S_HDR;
               err_d   = ERR_NONE;
               cnt_d   = '0;
               sum_d   = '0;
            end
         end
         S_HDR: begin
            if (accept) begin
               len_d = hdr_len;
               if (hdr_len > DEPTH) begin
                  state_d = S_ERROR;
                  err_d   = ERR_LEN;
               end else if (s_last) begin
                  state_d = S_ERROR;
                  err_d   = ERR_FRAME;
               end else if (hdr_len == '0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (s_last) begin
                  // A premature end-of-frame beat is never written.
                  state_d = S_ERROR;
                  err_d   = ERR_FRAME;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = cnt_q[ADDR_W-1:0];
                  wdata_d = s_data;
                  cnt_d   = cnt_inc;
                  sum_d   = sum_q + s_data;
                  if (cnt_inc == len_q) begin
                     state_d = S_CSUM;
                  end
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (!s_last) begin
                  state_d = S_ERROR;
                  err_d   = ERR_FRAME;
               end else if (s_data != sum_q) begin
                  state_d = S_ERROR;
                  err_d   = ERR_CSUM;
               end else begin
                  state_d = S_HOLD;
                  hold_d  = '0;
               end
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_RUN;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d   = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CSUM);
      busy_d    = ready_d || (state_d == S_HOLD);
      cpu_rst_d = (state_d != S_RUN);
      done_d    = (state_d == S_RUN);
   end

   // State and output registers; reset aborts any load in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         sum_q     <= '0;
         hold_q    <= '0;
         err_q     <= ERR_NONE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ready_q   <= 1'b0;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         hold_q    <= hold_d;
         err_q     <= err_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ready_q   <= ready_d;
         cpu_rst_q <= cpu_rst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign s_ready    = ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_count = cnt_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader that is the writer side of the instruction memory the pipeline fetch stage reads. It accepts a framed word stream (length header, payload, checksum) over a valid/ready interface and writes the payload into instruction memory from address 0 upward. It holds the CPU in reset until the image is loaded and its checksum verifies, then releases it. It replaces backdoor memory pokes for bring-up and ASIC test.

Parameters:
ADDR_W, 8, instruction memory word-address width; depth = 2**ADDR_W words
DATA_W, 32, instruction word width
RST_HOLD, 4, cycles cpu_rst stays high after a good checksum before release (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a load
s_valid  in  1  stream beat valid
s_data  in  DATA_W  stream beat data
s_last  in  1  marks the final (checksum) beat
s_ready  out  1  loader accepts beat
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  instruction memory word address
imem_wdata  out  DATA_W  instruction memory write data
cpu_rst  out  1  reset to the CPU core, active-high
busy  out  1  load in progress (HDR/LOAD/CSUM/HOLD)
done  out  1  image verified and CPU released
err  out  2  0 none, 1 length, 2 framing, 3 checksum
word_count  out  ADDR_W+1  payload words written this load

Behaviour:
- Reset values: state IDLE, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, word_count=0, internal sum=0.
- States are IDLE, HDR, LOAD, CSUM, HOLD, RUN and ERROR. A beat is accepted when s_valid&&s_ready. s_ready=1 only in HDR, LOAD and CSUM, and is a registered state decode.
- IDLE: start moves to HDR. This clears err, done, word_count and sum.
- HDR: the accepted beat gives N = s_data[ADDR_W:0].
  - If N > 2**ADDR_W, go to ERROR with err=1.
  - If s_last=1, go to ERROR with err=2.
  - If N=0, go to CSUM.
  - Otherwise go to LOAD.
- LOAD: each accepted beat produces, on the next cycle only, imem_we=1, imem_addr=word_count[ADDR_W-1:0] and imem_wdata=s_data. word_count increments and sum += s_data (mod 2**DATA_W).
  - If s_last=1 on a payload beat, go to ERROR with err=2. That beat is not written.
  - After the Nth beat, go to CSUM.
- CSUM: the accepted beat must have s_last=1, otherwise go to ERROR with err=2.
  - If s_data != sum, go to ERROR with err=3.
  - If they match, go to HOLD.
- HOLD: counts RST_HOLD cycles with cpu_rst=1, then goes to RUN. In RUN, cpu_rst=0 and done=1 on the same edge.
- RUN: start reasserts cpu_rst=1 and clears done on the next edge, then moves to HDR. This is a reload.
- ERROR: cpu_rst=1, err holds, s_ready=0. Only start (to HDR) or rst leaves this state. Memory already written is not erased.
- cpu_rst=1 in every state except RUN.
- start is ignored in HDR, LOAD, CSUM and HOLD.
- s_valid without s_ready is ignored. Data is not sampled.
- Stalls (s_valid low) of any length are legal in any stream state.
- Beat counting uses ADDR_W+1 bits so N = 2**ADDR_W is a legal full-memory load. imem_addr wraps never occur.
- rst mid-load aborts immediately to the reset values. The partial image remains in memory.
- imem_we is never asserted outside the cycle after a LOAD acceptance.

Test Plan:
1. Nominal load. Stimulus: start, then beats 3, 0x20010005, 0x20020007, 0x00221820, then 0x4025182C with s_last, all s_valid=1.
   - Required: three imem_we pulses at addresses 0, 1, 2 with matching data, and word_count=3.
   - Required: cpu_rst drops exactly RST_HOLD+1 cycles after the checksum beat, with done=1 and err=0.
   - With the CPU attached, r3=12 after 20 cycles.
2. Bad checksum. Same stream as scenario 1 with the checksum beat 0x4025182D.
   - Required: err=3, cpu_rst stays 1, done=0, no further s_ready.
   - A new start followed by the correct stream recovers to done=1.
3. Framing errors.
   - s_last on payload beat 2: err=2, only address 0 is written.
   - Checksum beat with s_last=0: err=2.
   - Header with N=257 (ADDR_W=8): err=1 and no imem_we.
4. Backpressure and edge sizes.
   - Random s_valid gaps on the scenario 1 stream give an identical result.
   - N=0 with checksum 0 reaches done.
   - N=256 fills addresses 0..255, and word_count=256.
5. Control corner cases.
   - start pulsed during LOAD is ignored.
   - rst asserted mid-LOAD forces cpu_rst=1 and state IDLE asynchronously.
   - start in RUN reasserts cpu_rst on the next edge, and a reload completes with the new image.
